// File: rtl/rv32_pkg.sv
// rv32_pkg: shared opcodes, command kinds, error codes and loader states
package rv32_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {K_LW = 2'd0, K_SW = 2'd1, K_BEQ = 2'd2, K_ILL = 2'd3} kind_t;
  typedef enum logic [1:0] {E_NONE = 2'd0, E_KIND = 2'd1, E_IMM = 2'd2, E_OVF = 2'd3} err_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: command channel and instruction-memory write channel
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_last, mem_gnt,
    output in_ready, mem_req, mem_addr, mem_wdata
  );
  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm, in_last, mem_gnt,
    input  in_ready, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: validates a command and packs its offset into I/S/B immediate positions
module instr_pack
  import rv32_pkg::*;
(
  input  kind_t       kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  f3,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output err_t        code
);
  logic fits12, fits13;
  // a value fits n signed bits when everything above bit n-1 is a sign copy
  assign fits12 = imm[31:11] == {21{imm[11]}};
  assign fits13 = imm[31:12] == {20{imm[12]}};
  always_comb begin
    word = kind == K_SW  ? {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE} :
           kind == K_BEQ ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH} :
                           {imm[11:0], rs1, f3, rd, OP_LOAD};
    code = kind == K_ILL ? E_KIND :
           (kind == K_BEQ ? !(fits13 && !imm[0]) : !fits12) ? E_IMM : E_NONE;
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes lw/sw/beq commands and writes them to consecutive imem words
module instr_encoder_loader
  import rv32_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [31:0]                 base_addr,
  instr_encoder_loader_if.slave       bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic [$clog2(MAX_WORDS):0]  count
);
  localparam int CW = $clog2(MAX_WORDS) + 1;
  state_t      state, next;
  err_t        code, err_q;
  logic [31:0] word;
  logic        last_q, hs, gnt, go, full;
  instr_pack u_pack (
    .kind (kind_t'(bus.in_kind)),
    .rd   (bus.in_rd),
    .rs1  (bus.in_rs1),
    .rs2  (bus.in_rs2),
    .f3   (bus.in_funct3),
    .imm  (bus.in_imm),
    .word (word),
    .code (code)
  );
  assign hs           = state == S_LOAD && bus.in_valid;
  assign gnt          = state == S_WRITE && bus.mem_gnt;
  assign go           = (state == S_IDLE || state == S_ERR) && start;
  assign full         = count == CW'(MAX_WORDS - 1);
  assign bus.in_ready = state == S_LOAD;
  assign bus.mem_req  = state == S_WRITE;
  assign busy         = state == S_LOAD || state == S_WRITE;
  assign done         = state == S_DONE;
  assign err          = state == S_ERR;
  assign err_code     = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE, S_ERR: next = start ? S_LOAD : state;
      S_LOAD:        next = !hs ? S_LOAD : code == E_NONE ? S_WRITE : S_ERR;
      S_WRITE:       next = !gnt ? S_WRITE : last_q ? S_DONE : full ? S_ERR : S_LOAD;
      S_DONE:        next = S_IDLE;
      default:       next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      count         <= '0;
      err_q         <= E_NONE;
      last_q        <= 1'b0;
    end else begin
      if (go) begin
        bus.mem_addr <= {base_addr[31:2], 2'b00};
        count        <= '0;
        err_q        <= E_NONE;
      end
      if (hs) begin
        bus.mem_wdata <= word;
        last_q        <= bus.in_last;
        if (code != E_NONE) err_q <= code;
      end
      if (gnt) begin
        bus.mem_addr <= bus.mem_addr + 32'd4;
        count        <= count + 1'b1;
        if (!last_q && full) err_q <= E_OVF;
      end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed and randomized checks of the instruction encoder/loader
module tb_instr_encoder_loader;
  import rv32_pkg::*;
  logic clk = 1'b0, rst_n, start;
  logic [31:0] base_addr;
  logic busy, done, err, busy4, done4, err4;
  logic [1:0] err_code, ec4;
  logic [8:0] count;
  logic [2:0] cnt4;
  int n_vec = 0, n_bad = 0;
  instr_encoder_loader_if b ();
  instr_encoder_loader_if b4 ();
  assign b4.in_valid  = b.in_valid;
  assign b4.in_kind   = b.in_kind;
  assign b4.in_rd     = b.in_rd;
  assign b4.in_rs1    = b.in_rs1;
  assign b4.in_rs2    = b.in_rs2;
  assign b4.in_funct3 = b.in_funct3;
  assign b4.in_imm    = b.in_imm;
  assign b4.in_last   = b.in_last;
  assign b4.mem_gnt   = b.mem_gnt;
  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(b.slave),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
  );
  instr_encoder_loader #(.MAX_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(b4.slave),
    .busy(busy4), .done(done4), .err(err4), .err_code(ec4), .count(cnt4)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [31:0] a);
    start = 1'b1;
    base_addr = a;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [1:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                      input logic last);
    b.in_kind = k; b.in_rd = rd; b.in_rs1 = rs1; b.in_rs2 = rs2;
    b.in_funct3 = f3; b.in_imm = imm; b.in_last = last; b.in_valid = 1'b1;
    for (int i = 0; i < 20 && !b.in_ready; i++) tick();
    chk("send_rdy", b.in_ready, 1);
    tick();
    b.in_valid = 1'b0;
    b.in_last = 1'b0;
  endtask
  // capture the write, hold gnt off for dly cycles checking stability, then grant
  task automatic write_cap(input int dly, output logic [31:0] a, output logic [31:0] w);
    chk("wr_req", b.mem_req, 1);
    a = b.mem_addr;
    w = b.mem_wdata;
    for (int d = 0; d < dly; d++) begin
      tick();
      chk("wr_req_hold", b.mem_req, 1);
      chk("wr_rdy_low", b.in_ready, 0);
      chk("wr_addr_hold", b.mem_addr, a);
      chk("wr_data_hold", b.mem_wdata, w);
    end
    b.mem_gnt = 1'b1;
    tick();
    b.mem_gnt = 1'b0;
  endtask
  task automatic write_chk(input string tag, input int dly, input logic [31:0] ea,
                           input logic [31:0] ed);
    logic [31:0] a, w;
    write_cap(dly, a, w);
    chk({tag, "_addr"}, a, ea);
    chk({tag, "_data"}, w, ed);
  endtask
  task automatic err_case(input string tag, input logic [1:0] k, input logic [31:0] imm,
                          input logic [1:0] ec);
    do_start(32'h300);
    send(k, 5'd1, 5'd1, 5'd1, 3'd0, imm, 1'b1);
    chk({tag, "_req"}, b.mem_req, 0);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_code"}, err_code, ec);
    b.in_valid = 1'b1;
    repeat (3) tick();
    chk({tag, "_req_held"}, b.mem_req, 0);
    chk({tag, "_rdy_low"}, b.in_ready, 0);
    chk({tag, "_err_held"}, err, 1);
    chk({tag, "_code_held"}, err_code, ec);
    b.in_valid = 1'b0;
    do_start(32'h300);
    chk({tag, "_clr"}, err, 0);
    chk({tag, "_clr_code"}, err_code, 0);
    send(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b1);
    write_chk({tag, "_close"}, 0, 32'h300, 32'h0000_0003);
    tick();
  endtask
  function automatic logic [31:0] immgen(input logic [31:0] w);
    case (w[6:0])
      OP_LOAD:   return {{20{w[31]}}, w[31:20]};
      OP_STORE:  return {{20{w[31]}}, w[31:25], w[11:7]};
      OP_BRANCH: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction
  initial begin
    logic [31:0] a, w, imm;
    logic [1:0] k;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    int v;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; b.mem_gnt = 1'b0;
    b.in_valid = 1'b0; b.in_kind = '0; b.in_rd = '0; b.in_rs1 = '0; b.in_rs2 = '0;
    b.in_funct3 = '0; b.in_imm = '0; b.in_last = 1'b0;
    tick(); tick();
    chk("rst_rdy", b.in_ready, 0);
    chk("rst_req", b.mem_req, 0);
    chk("rst_addr", b.mem_addr, 0);
    chk("rst_data", b.mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_cnt", count, 0);
    rst_n = 1'b1;
    tick();
    do_start(32'h103);
    chk("t1_busy", busy, 1);
    send(2'b00, 5'd5, 5'd2, 5'd0, 3'b010, -32'sd4, 1'b1);
    write_chk("t1", 1, 32'h100, 32'hFFC1_2283);
    chk("t1_done", done, 1);
    chk("t1_cnt", count, 1);
    tick();
    chk("t1_done_off", done, 0);
    chk("t1_cnt_hold", count, 1);
    chk("t1_idle", busy, 0);
    do_start(32'h200);
    send(2'b01, 5'd0, 5'd3, 5'd6, 3'b010, 32'd8, 1'b0);
    write_chk("t2_sw", 3, 32'h200, 32'h0061_A423);
    chk("t2_no_done", done, 0);
    send(2'b10, 5'd0, 5'd1, 5'd2, 3'b000, -32'sd8, 1'b1);
    write_chk("t2_beq", 3, 32'h204, 32'hFE20_8CE3);
    chk("t2_done", done, 1);
    chk("t2_cnt", count, 2);
    tick();
    err_case("e_beq3", 2'b10, 32'd3, 2'd2);
    err_case("e_lw2048", 2'b00, 32'd2048, 2'd2);
    err_case("e_kind", 2'b11, 32'd0, 2'd1);
    err_case("e_beq4096", 2'b10, 32'd4096, 2'd2);
    do_start(32'h400);
    for (int i = 0; i < 4; i++) begin
      send(2'b00, 5'd1, 5'd1, 5'd0, 3'd0, 32'(i * 4), 1'b0);
      write_cap(0, a, w);
    end
    chk("ovf_err", err4, 1);
    chk("ovf_code", ec4, 3);
    chk("ovf_cnt", cnt4, 4);
    chk("ovf_busy", busy4, 0);
    chk("ovf_big_ok", err, 0);
    chk("ovf_big_cnt", count, 4);
    do_start(32'h500);
    chk("ovf_clr", err4, 0);
    chk("ovf_clr_code", ec4, 0);
    chk("ovf_clr_cnt", cnt4, 0);
    send(2'b00, 5'd1, 5'd1, 5'd0, 3'd0, 32'd0, 1'b1);
    chk("ovf4_addr", b4.mem_addr, 32'h500);
    write_chk("ovf_close", 0, 32'h410, 32'h0000_8083);
    chk("ovf_done", done, 1);
    chk("ovf_done4", done4, 1);
    tick();
    do_start(32'h600);
    send(2'b00, 5'd1, 5'd1, 5'd0, 3'd0, 32'd4, 1'b1);
    chk("ar_req_pre", b.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", b.mem_req, 0);
    chk("ar_rdy", b.in_ready, 0);
    chk("ar_addr", b.mem_addr, 0);
    chk("ar_data", b.mem_wdata, 0);
    chk("ar_busy", busy, 0);
    chk("ar_cnt", count, 0);
    tick();
    rst_n = 1'b1;
    b.in_valid = 1'b1;
    repeat (3) tick();
    chk("ar_idle_rdy", b.in_ready, 0);
    chk("ar_idle_req", b.mem_req, 0);
    chk("ar_idle_busy", busy, 0);
    b.in_valid = 1'b0;
    do_start(32'h1000);
    for (int i = 0; i < 20; i++) begin
      k = 2'($urandom_range(0, 2));
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom);
      v = int'($urandom_range(0, 4095)) - 2048;
      if (k == 2'b10) v = v * 2;
      imm = 32'(v);
      send(k, rd, rs1, rs2, f3, imm, i == 19);
      write_cap(int'($urandom_range(0, 2)), a, w);
      chk("rnd_addr", a, 32'h1000 + 32'(i * 4));
      chk("rnd_imm", immgen(w), imm);
      chk("rnd_rs1", w[19:15], rs1);
      chk("rnd_f3", w[14:12], f3);
      chk("rnd_op", w[6:0], k == 2'b00 ? OP_LOAD : k == 2'b01 ? OP_STORE : OP_BRANCH);
      if (k == 2'b00) chk("rnd_rd", w[11:7], rd);
      else chk("rnd_rs2", w[24:20], rs2);
    end
    chk("rnd_done", done, 1);
    chk("rnd_cnt", count, 20);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
